// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU: decodes ALUOp/Funct into a 4-bit operation,
// computes result and flags, and captures them one clock after a valid request.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       Operation,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             out_valid
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpNor = 4'b1100;

  logic [WIDTH-1:0] result_d, aluOut_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;
  logic             valid_q;
  logic [WIDTH-1:0] sum, diff;
  logic             signedLess;
  logic             unusedFunctBits;

  // Funct[5:4] only distinguishes R-type groups the ALU does not care about.
  assign unusedFunctBits = ^Funct[5:4];

  always_comb begin
    Operation = OpAdd;
    case (ALUOp)
      2'b00: Operation = OpAdd;
      2'b01: Operation = OpSub;
      2'b10: begin
        case (Funct[3:0])
          4'b0000: Operation = OpAdd;
          4'b0010: Operation = OpSub;
          4'b0100: Operation = OpAnd;
          4'b0101: Operation = OpOr;
          4'b0111: Operation = OpNor;
          4'b1010: Operation = OpSlt;
          default: Operation = OpAdd;
        endcase
      end
      default: Operation = OpAdd;
    endcase
  end

  assign sum  = A + B;
  assign diff = A - B;
  // Direct signed compare stays correct when A - B overflows.
  assign signedLess = $signed(A) < $signed(B);

  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    case (Operation)
      OpAnd: result_d = A & B;
      OpOr:  result_d = A | B;
      OpAdd: begin
        result_d   = sum;
        overflow_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OpSub: begin
        result_d   = diff;
        overflow_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OpSlt: result_d = {{(WIDTH-1){1'b0}}, signedLess};
      OpNor: result_d = ~(A | B);
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aluOut_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        aluOut_q   <= result_d;
        zero_q     <= zero_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign ALUOut    = aluOut_q;
  assign Zero      = zero_q;
  assign Overflow  = overflow_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed vectors.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  ALUOp;
  logic [5:0]  Funct;
  logic [31:0] A, B;
  logic [3:0]  Operation;
  logic [31:0] ALUOut;
  logic        Zero, Overflow, out_valid;

  int vectors = 0;
  int miscompares = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALUOp(ALUOp), .Funct(Funct),
    .A(A), .B(B), .Operation(Operation), .ALUOut(ALUOut), .Zero(Zero),
    .Overflow(Overflow), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    ALUOp    = op;
    Funct    = fn;
    A        = a;
    B        = b;
  endtask

  task automatic checkOp(input string tag, input logic [3:0] expOp);
    #1;
    vectors++;
    assert (Operation === expOp) else begin
      miscompares++;
      $error("[TB] FAIL %s Operation observed=%b expected=%b", tag, Operation, expOp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expOut, input logic expZero,
                             input logic expOvf, input logic expValid);
    vectors++;
    assert (ALUOut === expOut) else begin
      miscompares++;
      $error("[TB] FAIL %s ALUOut observed=%h expected=%h", tag, ALUOut, expOut);
    end
    vectors++;
    assert (Zero === expZero) else begin
      miscompares++;
      $error("[TB] FAIL %s Zero observed=%b expected=%b", tag, Zero, expZero);
    end
    vectors++;
    assert (Overflow === expOvf) else begin
      miscompares++;
      $error("[TB] FAIL %s Overflow observed=%b expected=%b", tag, Overflow, expOvf);
    end
    vectors++;
    assert (out_valid === expValid) else begin
      miscompares++;
      $error("[TB] FAIL %s out_valid observed=%b expected=%b", tag, out_valid, expValid);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    applyStimulus(1'b1, 2'b10, 6'b000000, 32'd10, 32'd6);
    checkOp("add_op", 4'b0010);
    @(negedge clk);
    checkOutput("add", 32'd16, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 2'b10, 6'b000010, 32'd0, 32'd1);
    checkOp("sub_op", 4'b0110);
    @(negedge clk);
    checkOutput("sub", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 2'b01, 6'b101010, 32'h1234, 32'h1234);
    checkOp("beq_op", 4'b0110);
    @(negedge clk);
    checkOutput("beq", 32'd0, 1'b1, 1'b0, 1'b1);

    applyStimulus(1'b1, 2'b10, 6'b101010, 32'h8000_0000, 32'd1);
    checkOp("slt_op", 4'b0111);
    @(negedge clk);
    checkOutput("slt_ovf", 32'd1, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 2'b10, 6'b101010, 32'd5, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("slt_false", 32'd0, 1'b1, 1'b0, 1'b1);

    applyStimulus(1'b1, 2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkOp("and_op", 4'b0000);
    @(negedge clk);
    checkOutput("and", 32'hF000_F000, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 2'b10, 6'b100101, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkOp("or_op", 4'b0001);
    @(negedge clk);
    checkOutput("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 2'b10, 6'b100111, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkOp("nor_op", 4'b1100);
    @(negedge clk);
    checkOutput("nor", 32'h000F_000F, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 2'b00, 6'b000000, 32'h7FFF_FFFF, 32'd1);
    checkOp("lw_op", 4'b0010);
    @(negedge clk);
    checkOutput("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b1);

    applyStimulus(1'b1, 2'b10, 6'b100010, 32'h8000_0000, 32'd1);
    @(negedge clk);
    checkOutput("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);

    applyStimulus(1'b1, 2'b11, 6'b000000, 32'd5, 32'd7);
    checkOp("op11", 4'b0010);
    @(negedge clk);
    checkOutput("op11_add", 32'd12, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 2'b10, 6'b000011, 32'd3, 32'd4);
    checkOp("funct_other_op", 4'b0010);
    @(negedge clk);
    checkOutput("funct_other", 32'd7, 1'b0, 1'b0, 1'b1);

    // Request coincident with reset is dropped; Operation still decodes.
    reset = 1'b1;
    applyStimulus(1'b1, 2'b01, 6'b000000, 32'd9, 32'd2);
    checkOp("op_in_reset", 4'b0110);
    @(negedge clk);
    checkOutput("reset_drop", 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    applyStimulus(1'b1, 2'b11, 6'b000000, 32'd5, 32'd7);
    @(negedge clk);
    checkOutput("post_reset", 32'd12, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b0, 2'b01, 6'b000000, 32'd3, 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d", i), 32'd12, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
